// File: rtl/sel_pri_pkg.sv
// Shared types and constants for the registered priority select.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sel_pri_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NSRC  = 4;

    // Grant lock state: LOCKED pins the grant to lock_idx for multi-beat transfers.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sel_pri_pick.sv
// Rotating first-set-bit picker: lowest request at or above base wins, wrapping.
// Latency: combinational.
// Backpressure: none; the caller gates the grant.
// Ports: req (request mask), base (scan start) -> grant (one-hot), idx, any.
module sel_pri_pick #(
    parameter int NSRC = 4,
    parameter int IDXW = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [IDXW-1:0] base,
    output logic [NSRC-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [2*NSRC-1:0] dbl;
    logic [2*NSRC-1:0] dbl_sh;
    logic [NSRC-1:0]   rot;
    int                pos;

    // Duplicating the mask lets a plain right shift act as a rotation by base.
    assign dbl    = {req, req};
    assign dbl_sh = dbl >> base;
    assign rot    = dbl_sh[NSRC-1:0];

    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = 0;
        for (int i = 0; i < NSRC; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                // Undo the rotation to recover the real source index.
                pos = i + int'(base);
                if (pos >= NSRC) begin
                    pos = pos - NSRC;
                end
                idx = IDXW'(pos);
            end
        end
        grant = any ? (NSRC'(1) << idx) : '0;
    end

endmodule

// File: rtl/sel_pri_arb.sv
// Priority select of NSRC valid/ready sources into a one-deep registered output slot.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle while out_ready=1.
// Backpressure: src_ready all zero while the slot is full and out_ready=0.
// Ports: src_data/src_valid/src_ready (packed sources), lock (hold grant),
//        out_data/out_idx/out_valid/out_ready (consumer side).
// Option: define SEL_PRI_ARB_RR_EN for a rotating priority base (rr_ptr).
module sel_pri_arb
    import sel_pri_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int IDXW  = clog2_min1(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_valid,
    output logic [NSRC-1:0]       src_ready,
    input  logic                  lock,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDXW-1:0]       out_idx,
    output logic                  out_valid,
    input  logic                  out_ready
);

    lock_state_t      state;
    logic [IDXW-1:0]  lock_idx;
    logic [IDXW-1:0]  base;
    logic [NSRC-1:0]  lock_bit;
    logic [NSRC-1:0]  cand;
    logic [NSRC-1:0]  grant;
    logic [IDXW-1:0]  win_idx;
    logic             win_any;
    logic [WIDTH-1:0] win_data;
    logic             slot_free;
    logic             xfer;

    assign slot_free = !out_valid || out_ready;

    // While locked only the held source may compete; an idle held source means no grant.
    assign lock_bit = NSRC'(1) << lock_idx;
    assign cand     = (state == LOCKED) ? (src_valid & lock_bit) : src_valid;

    sel_pri_pick #(
        .NSRC (NSRC),
        .IDXW (IDXW)
    ) u_pick (
        .req   (cand),
        .base  (base),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign win_data = src_data[win_idx*WIDTH +: WIDTH];

    // rst_n gating keeps sources from seeing an accept while the block is held in reset.
    assign src_ready = grant & {NSRC{slot_free & rst_n}};
    assign xfer      = win_any & slot_free & rst_n;

`ifdef SEL_PRI_ARB_RR_EN
    logic [IDXW-1:0] rr_ptr;

    assign base = rr_ptr;

    // Rotation freezes while locked so the base resumes after the locked burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer && state == UNLOCKED) begin
            rr_ptr <= (win_idx == IDXW'(NSRC-1)) ? '0 : win_idx + IDXW'(1);
        end
    end
`else
    assign base = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            lock_idx <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (xfer && lock) begin
                        state    <= LOCKED;
                        lock_idx <= win_idx;
                    end
                end
                LOCKED: begin
                    // Dropping lock releases regardless of whether a beat moves.
                    if (!lock) begin
                        state <= UNLOCKED;
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (slot_free) begin
            if (win_any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_idx   <= win_idx;
            end else begin
                // An empty slot reads as zero data; out_idx keeps its last value.
                out_valid <= 1'b0;
                out_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sel_pri_arb.sv
// Self-checking bench for sel_pri_arb: directed scenarios plus a random phase,
// all compared against a queue-based reference model of the slot and lock rules.
// Works with or without SEL_PRI_ARB_RR_EN.
module tb_sel_pri_arb;

    localparam int WIDTH = 32;
    localparam int NSRC  = 4;
    localparam int IDXW  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_valid;
    logic [NSRC-1:0]       src_ready;
    logic                  lock;
    logic [WIDTH-1:0]      out_data;
    logic [IDXW-1:0]       out_idx;
    logic                  out_valid;
    logic                  out_ready;

    sel_pri_arb #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .IDXW  (IDXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .lock      (lock),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        int               idx;
    } beat_t;

    beat_t            slot_q[$];
    bit               m_locked;
    int               m_lock_idx;
    int               m_rr;
    logic [WIDTH-1:0] d [NSRC];

    // Values seen at the last sampling point, for directed constant checks.
    logic [NSRC-1:0]  obs_ready;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_data;
    logic [IDXW-1:0]  obs_idx;

    function automatic void model_clear();
        slot_q.delete();
        m_locked   = 1'b0;
        m_lock_idx = 0;
        m_rr       = 0;
    endfunction

    // One cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
    // Entered and left just after a rising edge.
    task automatic step(input logic [NSRC-1:0] v, input logic lk, input logic rdy);
        bit               found;
        int               s;
        int               c;
        bit               free;
        logic [NSRC-1:0]  exp_ready;
        beat_t            b;
        src_valid = v;
        lock      = lk;
        out_ready = rdy;
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = d[i];

        found = 1'b0;
        s     = 0;
        for (int off = 0; off < NSRC; off++) begin
            c = (m_rr + off) % NSRC;
            if (!found && v[c] && (!m_locked || c == m_lock_idx)) begin
                found = 1'b1;
                s     = c;
            end
        end
        free      = (slot_q.size() == 0) || rdy;
        exp_ready = (free && found) ? NSRC'(1 << s) : '0;

        @(negedge clk);
        obs_ready = src_ready;
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_idx   = out_idx;
        chk("src_ready", 64'(src_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(slot_q.size() != 0));
        chk("out_data", 64'(out_data), (slot_q.size() != 0) ? 64'(slot_q[0].data) : 64'd0);
        if (slot_q.size() != 0) chk("out_idx", 64'(out_idx), 64'(slot_q[0].idx));

        @(posedge clk);
        if (free) begin
            if (slot_q.size() != 0) void'(slot_q.pop_front());
            if (found) begin
                b.data = d[s];
                b.idx  = s;
                slot_q.push_back(b);
            end
        end
`ifdef SEL_PRI_ARB_RR_EN
        if (free && found && !m_locked) m_rr = (s + 1) % NSRC;
`endif
        if (!m_locked) begin
            if (free && found && lk) begin
                m_locked   = 1'b1;
                m_lock_idx = s;
            end
        end else if (!lk) begin
            m_locked = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        model_clear();
        src_valid = '0;
        lock      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [IDXW-1:0] exp_seq [5];

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        src_valid = '0;
        src_data  = '0;
        lock      = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NSRC; i++) d[i] = '0;
        model_clear();
        #2;
        do_reset();

        // Fixed priority: lowest valid index wins.
        d[1] = 32'h11;
        d[2] = 32'h22;
        step(4'b1110, 1'b0, 1'b1);
        chk("t1_ready", 64'(obs_ready), 64'b0010);
        step(4'b0000, 1'b0, 1'b0);
        chk("t1_data", 64'(obs_data), 64'h11);
        chk("t1_idx", 64'(obs_idx), 64'd1);
        chk("t1_valid", 64'(obs_valid), 64'd1);

        // Backpressure: full slot, consumer stalled.
        d[0] = 32'hA0;
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, 1'b0, 1'b0);
            chk("t2_stall_ready", 64'(obs_ready), 64'd0);
            chk("t2_hold_data", 64'(obs_data), 64'h11);
        end
        step(4'b0001, 1'b0, 1'b1);
        chk("t2_accept", 64'(obs_ready), 64'b0001);
        step(4'b0000, 1'b0, 1'b1);
        chk("t2_data", 64'(obs_data), 64'hA0);

        // Drain to empty.
        step(4'b0000, 1'b0, 1'b1);
        chk("t3_valid", 64'(obs_valid), 64'd0);
        chk("t3_data", 64'(obs_data), 64'd0);

        // Lock holds the grant on source 0.
        do_reset();
        d[0] = 32'hB0;
        d[2] = 32'hB2;
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, 1'b1, 1'b1);
            chk("t4_lock_ready", 64'(obs_ready), 64'b0001);
        end
        step(4'b0100, 1'b1, 1'b1);
        chk("t4_locked_nogrant", 64'(obs_ready), 64'd0);
        step(4'b0100, 1'b0, 1'b1);
        chk("t4_release_cycle", 64'(obs_ready), 64'd0);
        chk("t4_drained", 64'(obs_valid), 64'd0);
        step(4'b0100, 1'b0, 1'b1);
        chk("t4_src2", 64'(obs_ready), 64'b0100);

        // All sources valid: rotating or fixed order.
        do_reset();
        for (int i = 0; i < NSRC; i++) d[i] = 32'hC0 + 32'(i);
`ifdef SEL_PRI_ARB_RR_EN
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
`else
        for (int i = 0; i < 5; i++) exp_seq[i] = 2'd0;
`endif
        step(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0, 1'b1);
            chk("t5_idx_seq", 64'(obs_idx), 64'(exp_seq[k]));
        end

        // Async reset mid-stream while locked with a full slot.
        do_reset();
        d[0] = 32'hD0;
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        #2;
        src_valid = 4'b0001;
        do_reset();
        d[3] = 32'hD3;
        step(4'b1000, 1'b0, 1'b1);
        chk("t6_ready3", 64'(obs_ready), 64'b1000);
        step(4'b0000, 1'b0, 1'b1);
        chk("t6_idx3", 64'(obs_idx), 64'd3);
        chk("t6_data3", 64'(obs_data), 64'hD3);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NSRC; i++) d[i] = $urandom;
            step(NSRC'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sel_pri_arb.md
Name: sel_pri_arb

Overview:
- Parametrised, registered successor to the fixed 4x32 priority select.
- Selects one of NSRC valid/ready sources by priority (lowest index wins by default) and registers the winner's data and index into a one-deep output slot with a valid/ready handshake.
- Supports a lock input that holds the grant on one source for multi-beat transfers.
- Sits between load/store or fetch result producers and a single shared consumer port.

Parameters:
- WIDTH, 32, data width per source.
- NSRC, 4, number of sources (2..16).
- IDXW, $clog2(NSRC), width of the granted-index output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- src_data  in  NSRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- src_valid  in  NSRC  per-source request.
- src_ready  out  NSRC  per-source accept; one-hot or zero.
- lock  in  1  hold grant on the last-granted source.
- out_data  out  WIDTH  registered selected data.
- out_idx  out  IDXW  registered index of the granted source.
- out_valid  out  1  output slot full.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - out_valid=0, out_data=0, out_idx=0.
  - lock_idx=0, lock_active=0, rr_ptr=0.
  - src_ready=0 while rst_n=0.
- slot_free = !out_valid | out_ready (combinational).
- Winner selection (combinational):
  - Candidate mask = src_valid, restricted to bit lock_idx when lock_active=1.
  - Winner = first set bit scanning from priority base (base=0 without RR).
  - grant = one-hot winner; all zero if the mask is empty.
- src_ready[i] = slot_free & grant[i]. A transfer on source i occurs when src_valid[i] & src_ready[i].
- On a clock edge with slot_free:
  - If any grant: out_data<=winner data, out_idx<=winner index, out_valid<=1.
  - Else: out_valid<=0 and out_data<=0 (empty output reads zero, as in the combinational predecessor).
- When !slot_free: all output registers hold and src_ready=0. Sources must hold data and valid.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 transfer/cycle while out_ready=1.
- Lock state machine, states UNLOCKED/LOCKED:
  - UNLOCKED->LOCKED on a transfer with lock=1; lock_idx<=granted index.
  - LOCKED->UNLOCKED on a transfer with lock=0, or whenever lock=0 and no transfer occurs.
  - In LOCKED, other sources are never granted even if valid. If the locked source is not valid, there is no grant, the slot drains, and out_valid falls to 0.
- Simultaneous out_ready=1 and new winner: the old beat leaves and the new beat loads on the same edge, with no bubble.
- Reset mid-transfer: the beat in the slot is discarded and the lock is released.
- NSRC not a power of two: indices >= NSRC never appear. out_idx is zero-extended.

Optional Feature:
- Macro: SEL_PRI_ARB_RR_EN.
- Defined:
  - Priority base = rr_ptr.
  - After each transfer from source k while UNLOCKED: rr_ptr <= (k+1) mod NSRC.
  - rr_ptr is not updated while LOCKED.
- Undefined: base fixed at 0 (strict lowest-index priority); rr_ptr is not implemented.

Decomposition:
- Package sel_pri_pkg:
  - default WIDTH/NSRC constants;
  - lock state enum (UNLOCKED, LOCKED);
  - function clog2_min1.
- Sub-module sel_pri_pick (combinational, parameters NSRC):
  - inputs: request mask and base;
  - outputs: one-hot grant, index, any.
  - Instantiated once. The rotation is done inside it by double-width mask scan.

Test Plan:
1. Fixed priority: src_valid=4'b1110, data1=32'h11, data2=32'h22, out_ready=1.
   - Cycle 1: src_ready=4'b0010.
   - Cycle 2: out_data=32'h11, out_idx=1, out_valid=1.
2. Backpressure: out_valid=1, out_ready=0, src_valid=4'b0001.
   - src_ready=0, outputs hold for 5 cycles.
   - out_ready=1: src0 accepted the same cycle, out_data=src0 the next cycle.
3. Drain to empty: single beat then src_valid=0, out_ready=1.
   - out_valid 1 then 0, with out_data=0 after the drain edge.
4. Lock:
   - src_valid=4'b0101, lock=1 for 3 beats: all 3 beats come from idx 0.
   - src0 drops valid with lock=1: no grant, src2 not accepted.
   - lock=0: src2 granted next.
5. RR (SEL_PRI_ARB_RR_EN defined): all 4 sources valid continuously, out_ready=1.
   - out_idx sequence 0,1,2,3,0.
   - Without the macro: 0,0,0,0,0.
6. Async reset: assert rst_n=0 mid-stream with out_valid=1, LOCKED.
   - Immediately: out_valid=0, src_ready=0.
   - After release with src_valid=4'b1000: idx 3 is granted.
